// File: rtl/net_packet_decoder.sv
// Network packet decoder: turns addressed packets into imem/register-file/PC/barrier
// writes and runs a HALTED/RUN state machine with saturating packet and drop counters.
module net_packet_decoder #(
  parameter logic [9:0] core_id_p         = 10'h001,
  parameter int         imem_addr_width_p = 10,
  parameter int         mask_length_p     = 3
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [60:0]                  net_packet_i,
  input  logic                         halt_i,
  output logic                         imem_we_o,
  output logic [imem_addr_width_p-1:0] imem_addr_o,
  output logic [31:0]                  imem_data_o,
  output logic                         rf_we_o,
  output logic [4:0]                   rf_addr_o,
  output logic [31:0]                  rf_data_o,
  output logic                         pc_we_o,
  output logic [imem_addr_width_p-1:0] pc_o,
  output logic [mask_length_p-1:0]     barrier_mask_o,
  output logic                         run_o,
  output logic [15:0]                  pkt_count_o,
  output logic [15:0]                  drop_count_o
);

  typedef enum logic [0:0] {
    ST_HALTED = 1'b0,
    ST_RUN    = 1'b1
  } state_e;

  localparam logic [2:0] OP_NULL  = 3'd0;
  localparam logic [2:0] OP_INSTR = 3'd1;
  localparam logic [2:0] OP_REG   = 3'd2;
  localparam logic [2:0] OP_PC    = 3'd3;
  localparam logic [2:0] OP_BAR   = 3'd4;
  localparam logic [9:0] BCAST_ID = 10'h3FF;

  function automatic logic [15:0] sat_inc(input logic [15:0] value);
    if (value == 16'hFFFF) begin
      return value;
    end else begin
      return value + 16'd1;
    end
  endfunction

  state_e                         state_q, state_d;
  logic                           imem_we_q, imem_we_d;
  logic [imem_addr_width_p-1:0]   imem_addr_q, imem_addr_d;
  logic [31:0]                    imem_data_q, imem_data_d;
  logic                           rf_we_q, rf_we_d;
  logic [4:0]                     rf_addr_q, rf_addr_d;
  logic [31:0]                    rf_data_q, rf_data_d;
  logic                           pc_we_q, pc_we_d;
  logic [imem_addr_width_p-1:0]   pc_q, pc_d;
  logic [mask_length_p-1:0]       mask_q, mask_d;
  logic [15:0]                    pkt_count_q, pkt_count_d;
  logic [15:0]                    drop_count_q, drop_count_d;

  logic [9:0]                     pkt_id;
  logic [2:0]                     pkt_op;
  logic [imem_addr_width_p-1:0]   pkt_addr;
  logic [31:0]                    pkt_data;
  logic                           addressed;
  logic                           pc_load;
  logic                           pkt_inc;
  logic                           drop_inc;

  assign pkt_id    = net_packet_i[60:51];
  assign pkt_op    = net_packet_i[50:48];
  assign pkt_addr  = net_packet_i[32 +: imem_addr_width_p];
  assign pkt_data  = net_packet_i[31:0];
  assign addressed = (pkt_op != OP_NULL) && ((pkt_id == core_id_p) || (pkt_id == BCAST_ID));
  // A PC packet overrides a simultaneous halt request.
  assign pc_load   = addressed && (pkt_op == OP_PC);

  // Next-state, write decode and counter update.
  always_comb begin
    state_d      = state_q;
    imem_we_d    = 1'b0;
    imem_addr_d  = imem_addr_q;
    imem_data_d  = imem_data_q;
    rf_we_d      = 1'b0;
    rf_addr_d    = rf_addr_q;
    rf_data_d    = rf_data_q;
    pc_we_d      = 1'b0;
    pc_d         = pc_q;
    mask_d       = mask_q;
    pkt_count_d  = pkt_count_q;
    drop_count_d = drop_count_q;
    pkt_inc      = 1'b0;
    drop_inc     = 1'b0;

    if (reset) begin
      state_d      = ST_HALTED;
      imem_addr_d  = {imem_addr_width_p{1'b0}};
      imem_data_d  = 32'h0000_0000;
      rf_addr_d    = 5'd0;
      rf_data_d    = 32'h0000_0000;
      pc_d         = {imem_addr_width_p{1'b0}};
      mask_d       = {mask_length_p{1'b0}};
      pkt_count_d  = 16'h0000;
      drop_count_d = 16'h0000;
    end else begin
      if (addressed) begin
        case (pkt_op)
          OP_INSTR: begin
            if (state_q == ST_HALTED) begin
              imem_we_d   = 1'b1;
              imem_addr_d = pkt_addr;
              imem_data_d = pkt_data;
              pkt_inc     = 1'b1;
            end else begin
              drop_inc    = 1'b1;
            end
          end
          OP_REG: begin
            if (state_q == ST_HALTED) begin
              rf_we_d   = 1'b1;
              rf_addr_d = pkt_data[4:0] & 5'd0 | net_packet_i[36:32];
              rf_data_d = pkt_data;
              pkt_inc   = 1'b1;
            end else begin
              drop_inc  = 1'b1;
            end
          end
          OP_PC: begin
            pc_we_d = 1'b1;
            pc_d    = pkt_addr;
            mask_d  = pkt_data[mask_length_p-1:0];
            pkt_inc = 1'b1;
          end
          OP_BAR: begin
            mask_d  = pkt_data[mask_length_p-1:0];
            pkt_inc = 1'b1;
          end
          default: begin
            drop_inc = 1'b1;
          end
        endcase
      end else begin
        pkt_inc  = 1'b0;
        drop_inc = 1'b0;
      end

      if (pc_load) begin
        state_d = ST_RUN;
      end else if ((state_q == ST_RUN) && halt_i) begin
        state_d = ST_HALTED;
      end else begin
        state_d = state_q;
      end

      if (pkt_inc) begin
        pkt_count_d = sat_inc(pkt_count_q);
      end else begin
        pkt_count_d = pkt_count_q;
      end

      if (drop_inc) begin
        drop_count_d = sat_inc(drop_count_q);
      end else begin
        drop_count_d = drop_count_q;
      end
    end
  end

  // State, strobe and data registers.
  always_ff @(posedge clk) begin
    state_q      <= state_d;
    imem_we_q    <= imem_we_d;
    imem_addr_q  <= imem_addr_d;
    imem_data_q  <= imem_data_d;
    rf_we_q      <= rf_we_d;
    rf_addr_q    <= rf_addr_d;
    rf_data_q    <= rf_data_d;
    pc_we_q      <= pc_we_d;
    pc_q         <= pc_d;
    mask_q       <= mask_d;
    pkt_count_q  <= pkt_count_d;
    drop_count_q <= drop_count_d;
  end

  assign imem_we_o      = imem_we_q;
  assign imem_addr_o    = imem_addr_q;
  assign imem_data_o    = imem_data_q;
  assign rf_we_o        = rf_we_q;
  assign rf_addr_o      = rf_addr_q;
  assign rf_data_o      = rf_data_q;
  assign pc_we_o        = pc_we_q;
  assign pc_o           = pc_q;
  assign barrier_mask_o = mask_q;
  assign run_o          = (state_q == ST_RUN);
  assign pkt_count_o    = pkt_count_q;
  assign drop_count_o   = drop_count_q;

endmodule
